// File: rtl/codec_pkg.sv
// Shared types and defaults for the block compression controller.
package codec_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_SRC = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    OUT      = 3'd4
  } ctrl_state_t;

  localparam int BLOCK_SIZE   = 8;
  localparam int DEF_W_BLKS   = 80;
  localparam int DEF_H_BLKS   = 60;
  localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/blk_raster_cnt.sv
// Raster-order block x/y counter; advancing past the last block wraps to (0,0).
module blk_raster_cnt
  import codec_pkg::*;
#(
  parameter int W  = DEF_W_BLKS,
  parameter int H  = DEF_H_BLKS,
  parameter int XW = (W > 1) ? $clog2(W) : 1,
  parameter int YW = (H > 1) ? $clog2(H) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_adv,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last
);

  localparam logic [XW-1:0] XMAX = XW'(W - 1);
  localparam logic [YW-1:0] YMAX = YW'(H - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          w_x_end;
  logic          w_y_end;

  assign w_x_end = (r_x == XMAX);
  assign w_y_end = (r_y == YMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_last = w_x_end & w_y_end;

endmodule

// File: rtl/compress_ctrl.sv
// Frame sequencer: one block in flight from source fetch to output handshake.
// Optional RUN watchdog enabled by COMPRESS_CTRL_TIMEOUT_EN.
module compress_ctrl
  import codec_pkg::*;
#(
  parameter int IMG_W_BLKS     = DEF_W_BLKS,
  parameter int IMG_H_BLKS     = DEF_H_BLKS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int XW = (IMG_W_BLKS > 1) ? $clog2(IMG_W_BLKS) : 1,
  parameter int YW = (IMG_H_BLKS > 1) ? $clog2(IMG_H_BLKS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          src_valid,
  output logic          src_ack,
  output logic [XW-1:0] blk_x,
  output logic [YW-1:0] blk_y,
  output logic          start_block,
  input  logic          block_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done,
  output logic          timeout_err
);

  ctrl_state_t r_state;
  logic        r_src_ack;
  logic        r_frame_done;
  logic        w_last;
  logic        w_hs;
  logic        w_tmo;

  assign w_hs = (r_state == OUT) & out_ready;

`ifdef COMPRESS_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tcnt;
  logic          r_tmo_err;

  // r_tcnt holds (cycles already spent in RUN); fires on the last allowed one
  assign w_tmo = (r_state == RUN) & ~block_done &
                 (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt    <= '0;
      r_tmo_err <= 1'b0;
    end else begin
      r_tcnt <= (r_state == RUN) ? r_tcnt + 1'b1 : '0;
      if (w_tmo)
        r_tmo_err <= 1'b1;
    end
  end

  assign timeout_err = r_tmo_err;
`else
  logic w_unused_tmo;

  assign w_unused_tmo = TIMEOUT_CYCLES[0];
  assign w_tmo        = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  blk_raster_cnt #(
    .W  (IMG_W_BLKS),
    .H  (IMG_H_BLKS),
    .XW (XW),
    .YW (YW)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tmo),
    .i_adv  (w_hs),
    .o_x    (blk_x),
    .o_y    (blk_y),
    .o_last (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_src_ack    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_src_ack    <= 1'b0;
      r_frame_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (frame_start)
            r_state <= WAIT_SRC;
        end
        WAIT_SRC: begin
          if (src_valid)
            r_state <= START;
        end
        START: begin
          r_state <= RUN;
        end
        RUN: begin
          if (block_done) begin
            r_state   <= OUT;
            r_src_ack <= 1'b1;
          end else if (w_tmo) begin
            r_state   <= IDLE;
            r_src_ack <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (w_last) begin
              r_state      <= IDLE;
              r_frame_done <= 1'b1;
            end else begin
              r_state <= WAIT_SRC;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign src_ack     = r_src_ack;
  assign frame_done  = r_frame_done;
  assign start_block = (r_state == START);
  assign out_valid   = (r_state == OUT);
  assign out_last    = (r_state == OUT) & w_last;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_compress_ctrl.sv
// Directed + randomized checks of compress_ctrl on a 2x2 frame and a 1x1 frame.
module tb_compress_ctrl;

  localparam int W = 2;
  localparam int H = 2;
  localparam int T = 16;
  localparam int NB = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic src_valid = 1'b0;
  logic block_done = 1'b0;
  logic out_ready = 1'b0;
  logic src_ack, start_block, out_valid, out_last;
  logic busy, frame_done, timeout_err;
  logic [0:0] blk_x;
  logic [0:0] blk_y;

  logic fs1 = 1'b0;
  logic bd1 = 1'b0;
  logic src_ack1, start1, ov1, last1, busy1, fd1, tmo1;
  logic [0:0] x1;
  logic [0:0] y1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  compress_ctrl #(
    .IMG_W_BLKS     (W),
    .IMG_H_BLKS     (H),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .src_valid   (src_valid),
    .src_ack     (src_ack),
    .blk_x       (blk_x),
    .blk_y       (blk_y),
    .start_block (start_block),
    .block_done  (block_done),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  compress_ctrl #(
    .IMG_W_BLKS     (1),
    .IMG_H_BLKS     (1),
    .TIMEOUT_CYCLES (T)
  ) dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (fs1),
    .src_valid   (1'b1),
    .src_ack     (src_ack1),
    .blk_x       (x1),
    .blk_y       (y1),
    .start_block (start1),
    .block_done  (bd1),
    .out_valid   (ov1),
    .out_ready   (1'b1),
    .out_last    (last1),
    .busy        (busy1),
    .frame_done  (fd1),
    .timeout_err (tmo1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // model: block k of a raster frame sits at (k mod W, k div W)
  function automatic int ex(input int k);
    return k % W;
  endfunction

  function automatic int ey(input int k);
    return k / W;
  endfunction

  task automatic start_frame;
    chk("idle_busy", 32'(busy), 0);
    frame_start = 1'b1;
    tick;
    frame_start = 1'b0;
    chk("fs_busy", 32'(busy), 1);
    chk("fs_x", 32'(blk_x), 0);
    chk("fs_y", 32'(blk_y), 0);
  endtask

  task automatic do_block(input int k, input int sdly,
                          input int ddly, input int rdly,
                          input bit poke);
    bit last;
    last = (k == NB - 1);
    chk("ws_x", 32'(blk_x), 32'(ex(k)));
    chk("ws_y", 32'(blk_y), 32'(ey(k)));
    for (int i = 0; i < sdly; i++) begin
      src_valid = 1'b0;
      block_done = poke && (i == 0);
      tick;
      block_done = 1'b0;
      chk("ws_nostart", 32'(start_block), 0);
    end
    src_valid = 1'b1;
    tick;
    chk("start_pulse", 32'(start_block), 1);
    chk("start_noack", 32'(src_ack), 0);
    tick;
    chk("start_once", 32'(start_block), 0);
    for (int i = 0; i < ddly; i++) begin
      frame_start = poke && (i == 0);
      tick;
      frame_start = 1'b0;
      chk("run_noval", 32'(out_valid), 0);
      chk("run_busy", 32'(busy), 1);
    end
    block_done = 1'b1;
    tick;
    block_done = 1'b0;
    src_valid = 1'b0;
    chk("out_valid", 32'(out_valid), 1);
    chk("out_ack", 32'(src_ack), 1);
    chk("out_last", 32'(out_last), 32'(last));
    chk("out_x", 32'(blk_x), 32'(ex(k)));
    chk("out_y", 32'(blk_y), 32'(ey(k)));
    for (int i = 0; i < rdly; i++) begin
      tick;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_ack", 32'(src_ack), 0);
      chk("hold_start", 32'(start_block), 0);
      chk("hold_x", 32'(blk_x), 32'(ex(k)));
      chk("hold_y", 32'(blk_y), 32'(ey(k)));
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("hs_valid", 32'(out_valid), 0);
    if (last) begin
      chk("hs_fdone", 32'(frame_done), 1);
      chk("hs_idle", 32'(busy), 0);
      chk("hs_x0", 32'(blk_x), 0);
      chk("hs_y0", 32'(blk_y), 0);
      tick;
      chk("fdone_pulse", 32'(frame_done), 0);
    end else begin
      chk("hs_nofd", 32'(frame_done), 0);
      chk("hs_busy", 32'(busy), 1);
      chk("hs_nx", 32'(blk_x), 32'(ex(k + 1)));
      chk("hs_ny", 32'(blk_y), 32'(ey(k + 1)));
    end
  endtask

  initial begin
    tick;
    tick;
    chk("rst_ack", 32'(src_ack), 0);
    chk("rst_start", 32'(start_block), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    chk("rst_tmo", 32'(timeout_err), 0);
    chk("rst_xy", 32'({blk_x, blk_y}), 0);
    rst_n = 1'b1;
    tick;

    fs1 = 1'b1;
    tick;
    fs1 = 1'b0;
    tick;
    chk("f1_start", 32'(start1), 1);
    tick;
    bd1 = 1'b1;
    tick;
    bd1 = 1'b0;
    chk("f1_valid", 32'(ov1), 1);
    chk("f1_last", 32'(last1), 1);
    chk("f1_ack", 32'(src_ack1), 1);
    tick;
    chk("f1_fdone", 32'(fd1), 1);
    chk("f1_idle", 32'(busy1), 0);
    chk("f1_xy", 32'({x1, y1}), 0);

    start_frame;
    for (int k = 0; k < NB; k++)
      do_block(k, 0, 4, 0, 1'b0);

    start_frame;
    do_block(0, 0, 2, 0, 1'b1);
    do_block(1, 1, 3, 10, 1'b0);
    do_block(2, 7, 1, 0, 1'b1);
    do_block(3, 0, 0, 2, 1'b0);

    for (int f = 0; f < 3; f++) begin
      start_frame;
      for (int k = 0; k < NB; k++)
        do_block(k, int'($urandom_range(0, 6)),
                 int'($urandom_range(1, 8)),
                 int'($urandom_range(0, 5)),
                 1'($urandom_range(0, 1)));
    end

    start_frame;
    do_block(0, 0, 1, 0, 1'b0);
    src_valid = 1'b1;
    tick;
    tick;
    block_done = 1'b1;
    tick;
    block_done = 1'b0;
    src_valid = 1'b0;
    chk("pre_rst_x", 32'(blk_x), 1);
    chk("pre_rst_val", 32'(out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ack", 32'(src_ack), 0);
    chk("arst_last", 32'(out_last), 0);
    chk("arst_xy", 32'({blk_x, blk_y}), 0);
    tick;
    rst_n = 1'b1;
    tick;
    start_frame;
    for (int k = 0; k < NB; k++)
      do_block(k, int'($urandom_range(0, 3)), 2, 1, 1'b0);

    start_frame;
    src_valid = 1'b1;
    tick;
    tick;
    src_valid = 1'b0;
`ifdef COMPRESS_CTRL_TIMEOUT_EN
    for (int i = 1; i < T; i++) begin
      tick;
      chk("tmo_wait_ack", 32'(src_ack), 0);
      chk("tmo_wait_err", 32'(timeout_err), 0);
    end
    tick;
    chk("tmo_ack", 32'(src_ack), 1);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_nofd", 32'(frame_done), 0);
    tick;
    chk("tmo_ack_pulse", 32'(src_ack), 0);
    chk("tmo_sticky", 32'(timeout_err), 1);
`else
    for (int i = 0; i < 40; i++) begin
      tick;
      chk("nto_busy", 32'(busy), 1);
      chk("nto_ack", 32'(src_ack), 0);
      chk("nto_err", 32'(timeout_err), 0);
    end
    block_done = 1'b1;
    tick;
    block_done = 1'b0;
    chk("nto_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    for (int k = 1; k < NB; k++)
      do_block(k, 0, 1, 0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
